fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the synchronous FIFO (width 16, depth 16) between `n_req` producers. Each producer presents a word with a request; the arbiter grants one owner at a time, lets it stream up to `max_burst` words, and forwards accepted words onto `fifo_data_in`/`fifo_write`. It never writes while `fifo_full` is high. The arbiter sits directly in front of the FIFO write side; the read side is untouched.

## Interface
- `width`, 16, data word width; must match the FIFO width
- `n_req`, 4, number of requesters (2..8)
- `max_burst`, 4, maximum words per grant before forced rotation (1..15)

- `clk`  in  1  system clock; all state updates on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  n_req  per-requester valid; word on the matching `req_data` slice is offered while high
- `req_data`  in  n_req*width  packed words; requester i on bits [i*width +: width]
- `gnt`  out  n_req  registered one-hot grant, all-zero when idle
- `fifo_full`  in  1  FIFO full flag
- `fifo_write`  out  1  FIFO write strobe
- `fifo_data_in`  out  width  FIFO write data
- `owner`  out  $clog2(n_req)  index of the current grant holder; 0 when idle
- `busy`  out  1  high while any grant is held

## Operation
- State machine: IDLE, GRANT.
- Accept condition (combinational): `accept = |(gnt & req) && !fifo_full`. A word from requester i is consumed in exactly the cycle where `accept` is high and `gnt[i]` is set; the requester may change `req_data` on the next edge.
- `fifo_write = accept`; `fifo_data_in` = `req_data` slice of `owner` (mux driven even when not writing).
- IDLE: if `req` != 0, select the first set bit searching from `rr_ptr` upward, with modulo `n_req` wrap. Register `gnt`/`owner` and go to GRANT. `burst_cnt` is 0. If `req` == 0, stay in IDLE.
- GRANT: on each accept, `burst_cnt` increments. The grant is released at the edge where either:
  - `req[owner]` is low, or
  - an accept occurs with `burst_cnt == max_burst-1`.
- On release:
  - `rr_ptr` = (owner+1) mod n_req.
  - `burst_cnt` = 0.
  - Re-arbitration happens in the same cycle on the current `req` vector, masked to exclude a requester whose final burst word is being accepted this cycle only if others are requesting. If a winner exists, `gnt` moves to it with no idle cycle; otherwise go to IDLE.
  - If the releasing owner is the only requester, it is re-granted.
- `fifo_full` high in GRANT: no accept, `burst_cnt` holds, grant holds. A full FIFO alone never forces rotation.
- `req` of a non-owner is ignored until it wins arbitration. Dropping `req` of a non-owner has no effect.
- `busy` = (state == GRANT).

## Timing
- Reset values: `gnt`=0, `owner`=0, `busy`=0, `fifo_write`=0, `fifo_data_in`=0 (all `req_data` treated as don't-care, mux output forced 0 in reset). Internal: state=IDLE, `rr_ptr`=0, `burst_cnt`=0.
- Reset asserted mid-burst: all outputs return to reset values immediately (async). A word offered in that cycle is not written. After reset deasserts, arbitration restarts from requester 0.
- Latency from `req` rising (arbiter idle) to `gnt`: 1 cycle. First possible write occurs in that same granted cycle.
- Throughput: 1 word/cycle while the owner requests and the FIFO is not full. Owner-to-owner handover costs 0 cycles.
- `fifo_full` must be the FIFO's current-cycle flag. The arbiter relies on it combinationally and needs no lookahead.
- Simultaneous FIFO read/write is the FIFO's concern. The arbiter only guarantees no write while `fifo_full`=1.

## Test plan
- Reset, then `req`=4'b0001 with data 7 held for 6 cycles, FIFO empty -> `gnt`=0001 one cycle later. Writes of 7 are accepted as follows:
  - 4 writes, then release with re-grant to requester 0 since it is the only requester.
  - 2 more writes.
  - After that, `gnt`=0 and IDLE.
- `req`=4'b1111 continuous, data = requester index + 16'h10, `max_burst`=4 -> FIFO receives 4×0x10, 4×0x11, 4×0x12, 4×0x13, then 0x10 again, with no idle gaps.
- Owner 2 streaming, then `fifo_full` forced high for 3 cycles mid-burst -> `fifo_write`=0 for those cycles. `gnt` stays 0100 and `burst_cnt` is unchanged; the burst resumes and totals exactly 4 words.
- `req`=0110, then requester 1 drops `req` after 2 accepted words -> grant passes to requester 2 on the next edge, with no empty cycle.
- Async `rst` pulse in the middle of a cycle during the third word of a burst -> `gnt`, `fifo_write`, and `busy` go 0 without waiting for `clk`. Then `req`=1000 -> grant goes to requester 3.
- Fill FIFO to 16 from requester 0 with the read side idle -> exactly 16 writes and `fifo_full`=1. No 17th write occurs, and `gnt` is still held.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port between n_req producers
module fifo_wr_arbiter #(
  parameter int width     = 16,
  parameter int n_req     = 4,
  parameter int max_burst = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req,
  input  logic [n_req*width-1:0]   req_data,
  output logic [n_req-1:0]         gnt,
  input  logic                     fifo_full,
  output logic                     fifo_write,
  output logic [width-1:0]         fifo_data_in,
  output logic [$clog2(n_req)-1:0] owner,
  output logic                     busy
);

  localparam int ow = $clog2(n_req);
  localparam logic [ow-1:0] last_idx = ow'(n_req - 1);
  localparam logic [3:0] last_beat = 4'(max_burst - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [n_req-1:0] gnt_nxt;
  logic [ow-1:0]    owner_nxt;
  logic [ow-1:0]    rr_ptr, rr_ptr_nxt;
  logic [3:0]       burst_cnt, burst_cnt_nxt;
  logic [ow-1:0]    owner_inc;
  logic [ow-1:0]    base;
  logic [ow-1:0]    pick;
  logic             found;
  logic             accept;
  logic             release_gnt;

  // The grant already encodes ownership, so a word moves only when the owner offers and the FIFO has room.
  assign accept      = (|(gnt & req)) && !fifo_full;
  assign fifo_write  = accept;
  assign busy        = (state == GRANT);
  assign owner_inc   = (owner == last_idx) ? '0 : owner + 1'b1;
  assign release_gnt = !req[owner] || (accept && (burst_cnt == last_beat));

  // Data mux follows the owner at all times; forced to zero while reset is held.
  always_comb begin
    fifo_data_in = '0;
    if (!rst)
      fifo_data_in = req_data[int'(owner)*width +: width];
  end

  // Search starts just past the releasing owner, so it only wins again when nobody else is requesting.
  always_comb begin
    base  = (state == GRANT) ? owner_inc : rr_ptr;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < n_req; k++) begin
      if (!found && req[(int'(base) + k) % n_req]) begin
        found = 1'b1;
        pick  = ow'((int'(base) + k) % n_req);
      end
    end
  end

  // Next-state logic: grant, rotate on release, count beats of the current burst.
  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (found) begin
          gnt_nxt   = n_req'(1) << pick;
          owner_nxt = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_gnt) begin
          rr_ptr_nxt    = owner_inc;
          burst_cnt_nxt = '0;
          if (found) begin
            gnt_nxt   = n_req'(1) << pick;
            owner_nxt = pick;
          end else begin
            gnt_nxt   = '0;
            owner_nxt = '0;
            state_nxt = IDLE;
          end
        end else if (accept) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        owner_nxt = '0;
      end
    endcase
  end

  // State registers, cleared asynchronously so an in-flight write is dropped at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_write;
  logic [15:0] fifo_data_in;
  logic [1:0]  owner;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int wcount;

  typedef struct {
    logic [3:0]  req;
    logic        full;
    logic [3:0]  gnt;
    logic        wr;
    logic [15:0] data;
    logic        busy;
  } vec_t;

  vec_t vt[22];

  fifo_wr_arbiter #(.width(16), .n_req(4), .max_burst(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_data_in(fifo_data_in),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    fifo_full = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    fifo_full = 1'b0;
    req_data = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_write", 32'(fifo_write), 32'h0);
    chk("rst_data", 32'(fifo_data_in), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);

    // Table: all four requesting, round-robin bursts of four, then full stall and drain to idle.
    vt[0] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 16'h0010, 1'b0};
    for (int c = 1; c <= 16; c++)
      vt[c] = '{4'b1111, 1'b0, 4'b0001 << ((c - 1) / 4), 1'b1, 16'(16'h0010 + (c - 1) / 4), 1'b1};
    vt[17] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 16'h0010, 1'b1};
    vt[18] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 16'h0010, 1'b1};
    vt[19] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 16'h0010, 1'b1};
    vt[20] = '{4'b0000, 1'b0, 4'b0001, 1'b0, 16'h0010, 1'b1};
    vt[21] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 16'h0010, 1'b0};

    do_reset();
    for (int i = 0; i < 22; i++) begin
      req = vt[i].req;
      fifo_full = vt[i].full;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
      chk($sformatf("vec%0d_wr", i), 32'(fifo_write), 32'(vt[i].wr));
      if (vt[i].wr)
        chk($sformatf("vec%0d_data", i), 32'(fifo_data_in), 32'(vt[i].data));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      next_cycle();
    end

    // Single requester: 4 writes, re-grant with no gap, 2 more writes, then idle.
    do_reset();
    req_data[15:0] = 16'h0007;
    req = 4'b0001;
    @(negedge clk);
    chk("solo_idle_gnt", 32'(gnt), 32'h0);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("solo_gnt%0d", i), 32'(gnt), 32'h1);
      chk($sformatf("solo_wr%0d", i), 32'(fifo_write), 32'h1);
      chk($sformatf("solo_data%0d", i), 32'(fifo_data_in), 32'h7);
      next_cycle();
    end
    req = 4'b0000;
    @(negedge clk);
    chk("solo_drop_wr", 32'(fifo_write), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("solo_end_gnt", 32'(gnt), 32'h0);
    chk("solo_end_busy", 32'(busy), 32'h0);

    // Owner 2 stalls on a full FIFO for 3 cycles; burst still totals 4 words before rotation to 3.
    do_reset();
    req_data = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    req = 4'b1100;
    next_cycle();
    wcount = 0;
    for (int i = 0; i < 8; i++) begin
      fifo_full = (i >= 2 && i < 5);
      @(negedge clk);
      if (i >= 2 && i < 5) begin
        chk($sformatf("full_wr%0d", i), 32'(fifo_write), 32'h0);
        chk($sformatf("full_gnt%0d", i), 32'(gnt), 32'h4);
      end
      if (gnt == 4'b0100 && fifo_write) wcount++;
      if (i == 7) chk("full_rotate_gnt", 32'(gnt), 32'h8);
      next_cycle();
    end
    fifo_full = 1'b0;
    chk("full_burst_words", 32'(wcount), 32'd4);

    // Owner 1 drops after 2 words; grant moves to 2 on the next edge.
    do_reset();
    req = 4'b0110;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("drop_wr%0d", i), 32'(fifo_write & gnt[1]), 32'h1);
      next_cycle();
    end
    req = 4'b0100;
    @(negedge clk);
    chk("drop_hold_wr", 32'(fifo_write), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("drop_new_gnt", 32'(gnt), 32'h4);
    chk("drop_new_data", 32'(fifo_data_in), 32'h12);
    chk("drop_new_wr", 32'(fifo_write), 32'h1);

    // Async reset during the third word of a burst, then requester 3 wins.
    do_reset();
    req = 4'b0001;
    next_cycle();
    next_cycle();
    next_cycle();
    #3;
    chk("arst_pre_wr", 32'(fifo_write), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_wr", 32'(fifo_write), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_data", 32'(fifo_data_in), 32'h0);
    #1;
    rst = 1'b0;
    req = 4'b1000;
    next_cycle();
    chk("arst_after_gnt", 32'(gnt), 32'h8);
    chk("arst_after_owner", 32'(owner), 32'h3);
    chk("arst_after_data", 32'(fifo_data_in), 32'h13);

    // Fill a 16-deep FIFO from requester 0 with the read side idle.
    do_reset();
    req_data[15:0] = 16'h0055;
    req = 4'b0001;
    wcount = 0;
    for (int i = 0; i < 24; i++) begin
      fifo_full = (wcount >= 16);
      @(negedge clk);
      if (fifo_write) wcount++;
      next_cycle();
    end
    fifo_full = (wcount >= 16);
    @(negedge clk);
    chk("fill_words", 32'(wcount), 32'd16);
    chk("fill_no_17th", 32'(fifo_write), 32'h0);
    chk("fill_gnt", 32'(gnt), 32'h1);
    chk("fill_busy", 32'(busy), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
